// File: rtl/mdu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdu_pkg : shared op encodings, FSM state type and counter sizing      |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mul_div_unit_if : request/result and HI/LO write bus of the MDU       |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hilo_we;
    logic             hilo_sel;
    logic [WIDTH-1:0] hilo_wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    modport master (
        output start, op, a, b, hilo_we, hilo_sel, hilo_wdata,
        input  busy, done, lo, hi
    );

    modport slave (
        input  start, op, a, b, hilo_we, hilo_sel, hilo_wdata,
        output busy, done, lo, hi
    );
endinterface
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdu_step : one radix-2 iteration (shift-add multiply or restoring     |
// |            shift-subtract divide) on a 2*WIDTH accumulator            |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  wire logic               mode_div,
    input  wire logic [2*WIDTH-1:0] acc,
    input  wire logic [WIDTH-1:0]   operand,
    output logic      [2*WIDTH-1:0] acc_next,
    output logic                    q_bit
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;

    // Divide: acc = {remainder, dividend bits still to shift in / quotient}
    always_comb begin
        w_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        w_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        q_bit   = 1'b0;
        if (mode_div) begin
            q_bit    = ~w_trial[WIDTH];
            acc_next = {(q_bit ? w_trial[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]),
                        acc[WIDTH-2:0], q_bit};
        end else begin
            acc_next = {w_sum, acc[WIDTH-1:1]};
        end
    end
endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mul_div_unit : iterative signed/unsigned multiply/divide with         |
// |                architectural HI/LO registers and direct write port    |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input wire logic      clk,
    input wire logic      reset,
    mul_div_unit_if.slave bus
);
    localparam int             CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    mdu_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic               r_div;
    logic               r_div0;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_q_bit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    // Signed ops iterate on magnitudes; signs are reapplied in FIX
    always_comb begin
        w_a_neg = ~bus.op[0] & bus.a[WIDTH-1];
        w_b_neg = ~bus.op[0] & bus.b[WIDTH-1];
        w_a_mag = w_a_neg ? -bus.a : bus.a;
        w_b_mag = w_b_neg ? -bus.b : bus.b;
        w_prod  = r_neg_q ? -r_acc : r_acc;
        w_quo   = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem   = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .mode_div (r_div),
        .acc      (r_acc),
        .operand  (r_opnd),
        .acc_next (w_acc_next),
        .q_bit    (w_q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_a_raw <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_div   <= 1'b0;
            r_div0  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.hilo_we) begin
                        if (bus.hilo_sel) r_hi <= bus.hilo_wdata;
                        else              r_lo <= bus.hilo_wdata;
                    end
                    if (bus.start) begin
                        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_opnd  <= w_b_mag;
                        r_a_raw <= bus.a;
                        r_div   <= bus.op[1];
                        r_div0  <= (bus.b == '0);
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= {w_acc_next[2*WIDTH-1:1], r_div ? w_q_bit : w_acc_next[0]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_cnt   <= '0;
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (!r_div) begin
                        {r_hi, r_lo} <= w_prod;
                    end else if (r_div0) begin
                        r_lo <= '1;
                        r_hi <= r_a_raw;
                    end else begin
                        r_lo <= w_quo;
                        r_hi <= w_rem;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.lo   = r_lo;
    assign bus.hi   = r_hi;
endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mul_div_unit : vector table + scoreboard bench for mul_div_unit    |
// | Rev 1.0 : initial release                                             |
// +-----------------------------------------------------------------------+
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (op)
            OP_MULT:  res = 64'(sa * sb);
            OP_MULTU: res = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Scoreboard: every done pulse consumes one expected {hi,lo}
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done_without_request", 64'(bus.done), 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result_hi", 64'(bus.hi), 64'(e[63:32]));
                check("result_lo", 64'(bus.lo), 64'(e[31:0]));
            end
        end
    end

    // mode 0: plain; 1: start + hilo_we injected while busy; 2: LO write on the start edge
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] expect_hilo, input int mode);
        int          busy_n, done_n, done_cnt;
        logic [31:0] hi_before;
        hi_before = bus.hi;
        @(posedge clk); #1;
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        if (mode == 2) begin
            bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.hilo_wdata = 32'h0000_5555;
        end
        exp_q.push_back(expect_hilo);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hilo_we = 1'b0;
        busy_n = 0; done_n = -1; done_cnt = 0;
        for (int n = 0; n < LAT + 6; n++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_cnt++;
                done_n = n;
            end
            if (mode == 2 && n == 0) begin
                check({name, "_lo_write"}, 64'(bus.lo), 64'h5555);
                check({name, "_hi_hold"}, 64'(bus.hi), 64'(hi_before));
            end
            if (mode == 1 && n == 5) begin
                bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd9; bus.b = 32'd9;
                bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_wdata = 32'h1234;
            end
            if (mode == 1 && n == 6) begin
                bus.start = 1'b0; bus.hilo_we = 1'b0;
            end
            if (mode == 1 && n == 8) check({name, "_hi_busy_write"}, 64'(bus.hi), 64'(hi_before));
        end
        check({name, "_busy_cycles"}, 64'(busy_n), 64'(LAT));
        check({name, "_done_count"}, 64'(done_cnt), 64'd1);
        check({name, "_done_latency"}, 64'(done_n), 64'(LAT));
    endtask

    initial begin
        int dcnt;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.hilo_we = 1'b0; bus.hilo_sel = 1'b0; bus.hilo_wdata = '0;

        tbl[0]  = '{OP_MULTU, 32'd3,         32'd5,         32'h0000_000F, 32'h0000_0000};
        tbl[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
        tbl[2]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA, 32'hFFFF_FFFF};
        tbl[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
        tbl[4]  = '{OP_DIVU,  32'd7,         32'd2,         32'h0000_0003, 32'h0000_0001};
        tbl[5]  = '{OP_DIVU,  32'd10,        32'd0,         32'hFFFF_FFFF, 32'h0000_000A};
        tbl[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        tbl[7]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9};
        tbl[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001};
        tbl[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000};
        tbl[10] = '{OP_MULTU, 32'h8000_0000, 32'd2,         32'h0000_0000, 32'h0000_0001};
        tbl[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 32'h0000_0005};
        tbl[12] = '{OP_MULT,  32'd7,         32'hFFFF_FFFB, 32'hFFFF_FFDD, 32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_lo",   64'(bus.lo),   64'd0);
        check("reset_hi",   64'(bus.hi),   64'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, 0);

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb), 0);
        end

        run_op("busy_start", OP_MULTU, 32'd3, 32'd5, {32'd0, 32'd15}, 1);

        @(posedge clk); #1;
        bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_wdata = 32'h1234;
        @(posedge clk); #1;
        bus.hilo_we = 1'b0;
        @(negedge clk);
        check("idle_write_hi", 64'(bus.hi), 64'h1234);
        check("idle_write_lo_hold", 64'(bus.lo), 64'd15);

        @(posedge clk); #1;
        bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.hilo_wdata = 32'hABCD;
        @(posedge clk); #1;
        bus.hilo_we = 1'b0;
        @(negedge clk);
        check("idle_write_lo", 64'(bus.lo), 64'hABCD);
        check("idle_write_hi_hold", 64'(bus.hi), 64'h1234);

        run_op("start_with_write", OP_MULTU, 32'd2, 32'd3, {32'd0, 32'd6}, 2);

        // Abort a divide 10 cycles in
        @(posedge clk); #1;
        bus.op = OP_DIV; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_lo",   64'(bus.lo),   64'd0);
        check("abort_hi",   64'(bus.hi),   64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        dcnt = 0;
        for (int n = 0; n < LAT + 6; n++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);

        run_op("after_reset", OP_MULTU, 32'd2, 32'd2, {32'd0, 32'd4}, 0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
